video_store_buffer: RTL and testbench
=====================================

// Module: video_store_buffer
// PURPOSE
//   Decoupling buffer between the core's MEM-stage video tap and the framebuffer
//   RAM write port. The core cannot be back-pressured, so each store is captured
//   in a FIFO. The block translates the byte address to a word index relative to
//   VRAM base, drops out-of-range and overflowing stores with sticky status, and
//   drains entries to the framebuffer under a valid/ready handshake.
// PARAMETERS
//   VRAM_BASE   32'h0000_8000  first byte address of video memory
//   FB_WORDS    19200          framebuffer size in 32-bit words
//   FB_AW       15             framebuffer word-address width; must satisfy 2**FB_AW >= FB_WORDS
//   DEPTH       8              FIFO entries; power of two, >= 2
// PORTS
//   clk          in   1      clock, all logic on rising edge
//   rst          in   1      asynchronous active-high reset
//   video_we     in   1      store strobe from core (one store per cycle max)
//   video_addr   in   32     store byte address
//   video_data   in   32     store data
//   fb_valid     out  1      head entry is valid for the framebuffer
//   fb_ready     in   1      framebuffer accepts head this cycle
//   fb_addr      out  FB_AW  word index = (video_addr - VRAM_BASE) >> 2
//   fb_data      out  32     head data
//   level        out  log2(DEPTH)+1  current occupancy
//   overflow     out  1      sticky: at least one store dropped because the FIFO was full
//   range_err    out  1      sticky: at least one store dropped because it was out of range
//   drop_count   out  16     saturating count of all dropped stores
//   status_clr   in   1      synchronous clear of overflow, range_err, drop_count
// BEHAVIOUR
//   - Reset: FIFO empty, fb_valid=0, fb_addr=0, fb_data=0, level=0, overflow=0,
//     range_err=0, drop_count=0. Reset mid-drain discards all entries, and no
//     further fb_valid is asserted. An entry handed over in the reset cycle is the
//     sink's concern.
//   - In range: VRAM_BASE <= video_addr < VRAM_BASE + 4*FB_WORDS, computed in
//     33-bit unsigned arithmetic so no wrap occurs near 32'hFFFF_FFFF.
//     video_addr[1:0] is ignored (word stores only).
//   - Push: video_we && in range && (level<DEPTH || pop). Push writes the tail
//     entry {word index, data}.
//   - Pop: fb_valid && fb_ready. Pop advances the head.
//   - Latency: a store accepted in cycle N is presented at the outputs in N+1 if
//     the FIFO was empty. fb_addr and fb_data come from the registered head entry;
//     there is no combinational path from video_* to fb_*.
//   - fb_addr and fb_data must remain stable while fb_valid && !fb_ready.
//   - Full, no pop, video_we in range: store dropped; overflow<=1; drop_count+1.
//   - Full, pop in the same cycle: store accepted; level unchanged.
//   - Out of range with video_we: dropped; range_err<=1; drop_count+1. This applies
//     regardless of fill level, and overflow is not set.
//   - drop_count saturates at 16'hFFFF.
//   - status_clr with a simultaneous drop: the clear wins for that cycle, and the
//     drop is not recorded.
//   - Empty with simultaneous push: no pop. Pointers wrap modulo DEPTH. level is
//     the true occupancy, 0..DEPTH.
//   - Order is strict FIFO; stores are never coalesced or reordered.
// STRUCTURE
//   - Package video_pkg holds VRAM_BASE, FB_WORDS, FB_AW and the entry struct
//     {addr[FB_AW-1:0], data[31:0]}. Core's VRAM decode is to use the same
//     constant.
//   - One sub-module, video_sync_fifo: DEPTH x entry storage with read/write
//     pointers, level counter, registered head. The drop counter, sticky flags,
//     range check and address translation sit in the top level.
// TESTING
//   1. Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately;
//      deassert, fb_ready=1 -> fb_valid stays 0.
//   2. Single store: video_addr=32'h8010, data=32'hDEADBEEF, fb_ready=1 ->
//      next cycle fb_valid=1, fb_addr=4, fb_data=DEADBEEF; following cycle
//      fb_valid=0.
//   3. Backpressure: fb_ready=0, issue 9 in-range stores (DEPTH=8) -> level=8,
//      overflow=1, drop_count=1. Raise fb_ready -> the first 8 drain in issue
//      order; the 9th is absent.
//   4. Full with simultaneous pop: FIFO full, fb_ready=1, video_we=1 in the same
//      cycle -> store accepted, level stays 8, overflow stays 0.
//   5. Range edges: addr 32'h7FFC and 32'h8000+4*FB_WORDS -> dropped, range_err=1,
//      drop_count=2. Addr 32'h8000+4*FB_WORDS-4 -> accepted with
//      fb_addr=FB_WORDS-1. Addr 32'hFFFF_FFFC -> dropped (no wrap).
//   6. Status: preload drop_count=16'hFFFF, cause one more drop -> count holds at
//      FFFF. Pulse status_clr together with a drop -> all status fields 0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg
//   Shared constants and types for the video store path. The core's VRAM
//   address decode should use VRAM_BASE / FB_WORDS from here so both sides
//   agree on the window.
//   Contents:
//     VRAM_BASE        first byte address of video memory
//     FB_WORDS         framebuffer size in 32-bit words
//     FB_AW            framebuffer word-address width
//     fb_entry_t       one buffered store {word index, data}
//     vram_in_range    window check on a byte address
//     vram_word_index  byte address -> framebuffer word index
package video_pkg;

   localparam logic [31:0] VRAM_BASE = 32'h0000_8000;
   localparam int          FB_WORDS  = 19200;
   localparam int          FB_AW     = 15;

   typedef struct packed {
      logic [FB_AW-1:0] addr;
      logic [31:0]      data;
   } fb_entry_t;

   // Compared in 33 bits so the upper bound cannot wrap past 32'hFFFF_FFFF.
   // The byte offset within a word is masked off: stores are word stores.
   function automatic logic vram_in_range(input logic [31:0] byte_addr);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, byte_addr & 32'hFFFF_FFFC};
      lo = {1'b0, VRAM_BASE};
      hi = lo + (33'(FB_WORDS) << 2);
      return (a >= lo) && (a < hi);
   endfunction

   // Only meaningful for addresses that passed vram_in_range.
   function automatic logic [FB_AW-1:0] vram_word_index(input logic [31:0] byte_addr);
      return FB_AW'((byte_addr - VRAM_BASE) >> 2);
   endfunction

endpackage

// File: rtl/video_store_buffer_if.sv
// video_store_buffer_if
//   Bundles the core-side store tap and the framebuffer-side drain handshake.
//   master : the environment (core tap + framebuffer sink)
//   slave  : the store buffer
//   Signals:
//     video_we/video_addr/video_data  store strobe, byte address, data
//     fb_valid/fb_ready               drain handshake
//     fb_addr/fb_data                 head entry presented to the framebuffer
interface video_store_buffer_if;
   import video_pkg::*;

   logic                video_we;
   logic [31:0]         video_addr;
   logic [31:0]         video_data;
   logic                fb_valid;
   logic                fb_ready;
   logic [FB_AW-1:0]    fb_addr;
   logic [31:0]         fb_data;

   modport master (
      output video_we, video_addr, video_data, fb_ready,
      input  fb_valid, fb_addr, fb_data
   );

   modport slave (
      input  video_we, video_addr, video_data, fb_ready,
      output fb_valid, fb_addr, fb_data
   );

endinterface

// File: rtl/video_sync_fifo.sv
// video_sync_fifo
//   DEPTH-entry synchronous FIFO of fb_entry_t with a registered head.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     push        write wr_entry at the tail (caller guarantees space or pop)
//     pop         advance the head (caller guarantees head_valid)
//     wr_entry    entry to write
//     head        registered head entry
//     head_valid  registered: head holds a live entry
//     level       registered occupancy 0..DEPTH
module video_sync_fifo
   import video_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = PW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  fb_entry_t       wr_entry,
   output fb_entry_t       head,
   output logic            head_valid,
   output logic [LW-1:0]   level
);

   fb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr_d, wr_ptr_q;
   logic [PW-1:0]     rd_ptr_d, rd_ptr_q;
   logic [LW-1:0]     level_d, level_q;
   logic              valid_d, valid_q;
   fb_entry_t         head_d, head_q;

   // Next-state pointers, occupancy and head entry.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      valid_d = (level_d != LW'(0));

      // The new head is the entry being written this cycle when the write
      // lands on the next read slot (FIFO empty, or draining its last entry);
      // memory is not updated until the edge, so bypass it.
      if (valid_d) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_entry;
         end else begin
            head_d = mem[rd_ptr_d];
         end
      end else begin
         head_d = head_q;
      end
   end

   // Entry storage; no reset needed, occupancy qualifies every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_entry;
      end
   end

   // Control and head registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   assign head       = head_q;
   assign head_valid = valid_q;
   assign level      = level_q;

endmodule

// File: rtl/video_store_buffer.sv
// video_store_buffer
//   Decouples the core's MEM-stage video tap from the framebuffer write port.
//   Every store is either queued or dropped (the core cannot stall); drops are
//   reported through sticky flags and a saturating counter.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     vbus         store tap in, framebuffer drain handshake out (slave side)
//     level        occupancy 0..DEPTH
//     overflow     sticky: an in-range store was dropped because the FIFO was full
//     range_err    sticky: a store outside the VRAM window was dropped
//     drop_count   saturating count of all dropped stores
//     status_clr   synchronous clear of overflow, range_err, drop_count
module video_store_buffer
   import video_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   video_store_buffer_if.slave    vbus,
   output logic [LW-1:0]          level,
   output logic                   overflow,
   output logic                   range_err,
   output logic [15:0]            drop_count,
   input  logic                   status_clr
);

   fb_entry_t       wr_entry_s;
   fb_entry_t       head_s;
   logic            head_valid_s;
   logic [LW-1:0]   level_s;
   logic            in_range_s;
   logic            pop_s;
   logic            full_s;
   logic            push_s;
   logic            range_drop_s;
   logic            ovf_drop_s;
   logic            drop_s;

   logic            overflow_d, overflow_q;
   logic            range_err_d, range_err_q;
   logic [15:0]     drop_count_d, drop_count_q;

   // Store classification: accept, drop for range, or drop for overflow.
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   always_comb begin
      in_range_s       = vram_in_range(vbus.video_addr);
      pop_s            = head_valid_s && vbus.fb_ready;
      full_s           = (level_s == LW'(DEPTH));
      push_s           = vbus.video_we && in_range_s && (!full_s || pop_s);
      range_drop_s     = vbus.video_we && !in_range_s;
      ovf_drop_s       = vbus.video_we && in_range_s && full_s && !pop_s;
      drop_s           = range_drop_s || ovf_drop_s;
      wr_entry_s.addr  = vram_word_index(vbus.video_addr);
      wr_entry_s.data  = vbus.video_data;
   end

   // Sticky status next state; a clear discards any drop in the same cycle.
   always_comb begin
      overflow_d   = overflow_q;
      range_err_d  = range_err_q;
      drop_count_d = drop_count_q;
      if (status_clr) begin
         overflow_d   = 1'b0;
         range_err_d  = 1'b0;
         drop_count_d = 16'h0000;
      end else begin
         if (ovf_drop_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
         if (range_drop_s) begin
            range_err_d = 1'b1;
         end else begin
            range_err_d = range_err_q;
         end
         if (drop_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'h0001;
         end else begin
            drop_count_d = drop_count_q;
         end
      end
   end

   // Status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q   <= 1'b0;
         range_err_q  <= 1'b0;
         drop_count_q <= 16'h0000;
      end else begin
         overflow_q   <= overflow_d;
         range_err_q  <= range_err_d;
         drop_count_q <= drop_count_d;
      end
   end

   video_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .pop        (pop_s),
      .wr_entry   (wr_entry_s),
      .head       (head_s),
      .head_valid (head_valid_s),
      .level      (level_s)
   );

   assign vbus.fb_valid = head_valid_s;
   assign vbus.fb_addr  = head_s.addr;
   assign vbus.fb_data  = head_s.data;
   assign level         = level_s;
   assign overflow      = overflow_q;
   assign range_err     = range_err_q;
   assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_video_store_buffer.sv
// tb_video_store_buffer
//   Directed stimulus with a scoreboard: each store expected to be accepted
//   pushes {word index, data} into a queue; a monitor pops and compares on
//   every fb_valid && fb_ready handshake.
module tb_video_store_buffer;
   import video_pkg::*;

   logic          clk;
   logic          rst;
   logic [3:0]    level;
   logic          overflow;
   logic          range_err;
   logic [15:0]   drop_count;
   logic          status_clr;

   int            tests_run;
   int            tests_failed;
   logic [46:0]   sb_q [$];

   video_store_buffer_if vif ();

   video_store_buffer #(
      .DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vbus       (vif),
      .level      (level),
      .overflow   (overflow),
      .range_err  (range_err),
      .drop_count (drop_count),
      .status_clr (status_clr)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the run stalls.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: handshake sampled on the falling edge, transfer
   // happens at the following rising edge.
   always @(negedge clk) begin
      if (!rst && vif.fb_valid && vif.fb_ready) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_out: actual=addr 0x%0h data 0x%0h required=none",
                     vif.fb_addr, vif.fb_data);
         end else begin
            logic [46:0] e;
            e = sb_q.pop_front();
            if ({vif.fb_addr, vif.fb_data} !== e) begin
               tests_failed++;
               $display("FAIL sb_entry: actual=addr 0x%0h data 0x%0h required=addr 0x%0h data 0x%0h",
                        vif.fb_addr, vif.fb_data, e[46:32], e[31:0]);
            end
         end
      end
   end

   // One store cycle; inputs change 1 time unit after the rising edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input bit exp_acc, input logic [14:0] exp_idx);
      vif.video_we   = 1'b1;
      vif.video_addr = a;
      vif.video_data = d;
      if (exp_acc) sb_q.push_back({exp_idx, d});
      @(posedge clk);
      #1;
      vif.video_we = 1'b0;
   endtask

   task automatic clear_status();
      status_clr = 1'b1;
      @(posedge clk);
      #1;
      status_clr = 1'b0;
   endtask

   // Bounded wait for the scoreboard to empty.
   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
      check({name, "_valid"}, {31'd0, vif.fb_valid}, 32'd0);
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b1;
      status_clr     = 1'b0;
      vif.video_we   = 1'b0;
      vif.video_addr = 32'h0;
      vif.video_data = 32'h0;
      vif.fb_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1. Reset mid-cycle with content and status pending.
      store(32'h0000_0000, 32'h1111_1111, 1'b0, 15'd0);
      store(32'h0000_8020, 32'h2222_2222, 1'b0, 15'd0);
      @(negedge clk);
      check("pre_rst_level", 32'(level), 32'd1);
      check("pre_rst_range_err", {31'd0, range_err}, 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_valid", {31'd0, vif.fb_valid}, 32'd0);
      check("rst_addr", 32'(vif.fb_addr), 32'd0);
      check("rst_data", vif.fb_data, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_range_err", {31'd0, range_err}, 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      vif.fb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_valid", {31'd0, vif.fb_valid}, 32'd0);
      end

      // 2. Single store, one-cycle latency, then empty again.
      @(posedge clk);
      #1;
      store(32'h0000_8010, 32'hDEAD_BEEF, 1'b1, 15'd4);
      @(negedge clk);
      check("single_valid", {31'd0, vif.fb_valid}, 32'd1);
      @(negedge clk);
      check("single_valid_drop", {31'd0, vif.fb_valid}, 32'd0);

      // 3. Backpressure: 8 accepted, 9th dropped.
      vif.fb_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++)
         store(32'h0000_8000 + 32'(i * 4), 32'hA000_0000 + 32'(i), i < 8, 15'(i));
      @(negedge clk);
      check("bp_level", 32'(level), 32'd8);
      check("bp_overflow", {31'd0, overflow}, 32'd1);
      check("bp_drop_count", 32'(drop_count), 32'd1);
      check("bp_range_err", {31'd0, range_err}, 32'd0);
      check("bp_stable_addr", 32'(vif.fb_addr), 32'd0);
      check("bp_stable_data", vif.fb_data, 32'hA000_0000);
      vif.fb_ready = 1'b1;
      wait_drain("bp");
      clear_status();
      @(negedge clk);
      check("clr_overflow", {31'd0, overflow}, 32'd0);
      check("clr_drop_count", 32'(drop_count), 32'd0);

      // 4. Full with simultaneous pop, then out-of-range while full.
      vif.fb_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++)
         store(32'h0000_8040 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 15'h10 + 15'(i));
      @(negedge clk);
      check("full_level", 32'(level), 32'd8);
      @(posedge clk);
      #1;
      vif.fb_ready = 1'b1;
      store(32'h0000_8100, 32'hC0FF_EE00, 1'b1, 15'h40);
      vif.fb_ready = 1'b0;
      @(negedge clk);
      check("fullpop_level", 32'(level), 32'd8);
      check("fullpop_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      store(32'h0000_0000, 32'h3333_3333, 1'b0, 15'd0);
      @(negedge clk);
      check("full_oor_range_err", {31'd0, range_err}, 32'd1);
      check("full_oor_overflow", {31'd0, overflow}, 32'd0);
      check("full_oor_level", 32'(level), 32'd8);
      vif.fb_ready = 1'b1;
      wait_drain("fullpop");
      clear_status();

      // 5. Range edges (FB_WORDS=19200 -> window end 32'h1AC00).
      store(32'h0000_7FFC, 32'h4444_4444, 1'b0, 15'd0);
      store(32'h0001_AC00, 32'h5555_5555, 1'b0, 15'd0);
      @(negedge clk);
      check("edge_range_err", {31'd0, range_err}, 32'd1);
      check("edge_overflow", {31'd0, overflow}, 32'd0);
      check("edge_drop_count", 32'(drop_count), 32'd2);
      @(posedge clk);
      #1;
      store(32'h0001_ABFC, 32'h6666_6666, 1'b1, 15'd19199);
      store(32'hFFFF_FFFC, 32'h7777_7777, 1'b0, 15'd0);
      @(negedge clk);
      check("edge_wrap_drop_count", 32'(drop_count), 32'd3);
      wait_drain("edge");

      // 6. Saturation and clear-wins.
      @(posedge clk);
      #1;
      clear_status();
      vif.video_we   = 1'b1;
      vif.video_addr = 32'h0000_0000;
      repeat (65535) @(posedge clk);
      #1 vif.video_we = 1'b0;
      @(negedge clk);
      check("sat_reach", 32'(drop_count), 32'h0000_FFFF);
      @(posedge clk);
      #1;
      store(32'h0000_0004, 32'h8888_8888, 1'b0, 15'd0);
      @(negedge clk);
      check("sat_hold", 32'(drop_count), 32'h0000_FFFF);
      @(posedge clk);
      #1;
      status_clr     = 1'b1;
      vif.video_we   = 1'b1;
      vif.video_addr = 32'h0000_0000;
      @(posedge clk);
      #1;
      status_clr   = 1'b0;
      vif.video_we = 1'b0;
      @(negedge clk);
      check("clrwin_drop_count", 32'(drop_count), 32'd0);
      check("clrwin_range_err", {31'd0, range_err}, 32'd0);
      check("clrwin_overflow", {31'd0, overflow}, 32'd0);
      check("final_sb_left", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
